// File: rtl/fpnew_round_prep.sv
`default_nettype none
// ============================================================================
//  Package      : fpnew_pkg (minimal subset)
//  Description  : Rounding-mode encoding shared with the rounding stage.
//  Revision     : 1.0 - initial release
// ============================================================================
package fpnew_pkg;
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;
endpackage

// ============================================================================
//  Module       : fpnew_round_prep
//  Description  : Normalizes an unnormalized {sign, exponent, mantissa} result
//                 into a packed {exponent, mantissa} magnitude plus round and
//                 sticky bits. Two-stage elastic valid/ready pipeline:
//                 stage 1 finds the leading one and the shift, stage 2 shifts
//                 and packs the result.
//  Revision     : 1.0 - initial release
// ============================================================================
module fpnew_round_prep #(
  parameter int unsigned EXP_BITS = 8,
  parameter int unsigned MAN_BITS = 23,
  parameter int unsigned IN_WIDTH = 50
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          sign_i,
  input  logic signed [EXP_BITS+1:0]    exp_i,
  input  logic [IN_WIDTH-1:0]           mant_i,
  input  fpnew_pkg::roundmode_e         rnd_mode_i,
  input  logic                          eff_sub_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [EXP_BITS+MAN_BITS-1:0]  abs_value_o,
  output logic                          sign_o,
  output logic [1:0]                    round_sticky_o,
  output fpnew_pkg::roundmode_e         rnd_mode_o,
  output logic                          eff_sub_o,
  output logic                          of_before_rnd_o
);

  // Leading-zero count range is 0..IN_WIDTH; the normalized exponent is kept
  // wide enough that very negative inputs can never wrap into overflow.
  localparam int unsigned c_lzc_w  = $clog2(IN_WIDTH + 1);
  localparam int unsigned c_nexp_w = EXP_BITS + 3 + c_lzc_w;

  localparam logic signed [c_nexp_w-1:0] c_nexp_one = c_nexp_w'(1);
  localparam logic signed [c_nexp_w-1:0] c_exp_ovf  = c_nexp_w'((2**EXP_BITS) - 1);
  localparam logic signed [c_nexp_w-1:0] c_in_width = c_nexp_w'(IN_WIDTH);
  localparam logic [EXP_BITS-1:0]        c_exp_maxf = EXP_BITS'((2**EXP_BITS) - 2);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_s1_accept;
  logic w_s2_accept;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_accept = ~r_s2_valid | out_ready_i;
  assign w_s1_accept = ~r_s1_valid | w_s2_accept;
  assign in_ready_o  = w_s1_accept;
  assign out_valid_o = r_s2_valid;

  // --------------------------------------------------------------------------
  // Stage 1: leading-zero count, normalized exponent, class and shift amount
  // --------------------------------------------------------------------------
  logic [c_lzc_w-1:0]         w_lzc;
  logic signed [c_nexp_w-1:0] w_exp_ext;
  logic signed [c_nexp_w-1:0] w_lzc_ext;
  logic signed [c_nexp_w-1:0] w_nexp;
  logic signed [c_nexp_w-1:0] w_den_rsh;
  logic signed [c_nexp_w-1:0] w_den_lsh;
  logic                       w_zero;
  logic                       w_of;
  logic                       w_den;
  logic [EXP_BITS-1:0]        w_exp_field;
  logic [c_lzc_w-1:0]         w_shl;
  logic [c_lzc_w-1:0]         w_shr;

  // Leading-zero count: the highest set bit wins, IN_WIDTH when all zero
  always_comb begin
    w_lzc = c_lzc_w'(IN_WIDTH);
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      if (mant_i[i]) begin
        w_lzc = c_lzc_w'(int'(IN_WIDTH) - 1 - i);
      end
    end
  end

  assign w_exp_ext   = {{(c_nexp_w-EXP_BITS-2){exp_i[EXP_BITS+1]}}, exp_i};
  assign w_lzc_ext   = {{(c_nexp_w-c_lzc_w){1'b0}}, w_lzc};
  assign w_nexp      = w_exp_ext - w_lzc_ext + c_nexp_one;
  assign w_den_rsh   = c_nexp_one - w_exp_ext;
  assign w_den_lsh   = w_exp_ext - c_nexp_one;
  assign w_zero      = ~|mant_i;
  assign w_of        = (w_nexp >= c_exp_ovf);
  assign w_den       = (w_nexp < c_nexp_one);
  assign w_exp_field = w_den ? '0 : EXP_BITS'(w_nexp);

  // Shift that puts the leading one at bit IN_WIDTH-2 (normal) or aligns the
  // minimum exponent there (denormal); right shifts are clamped so every
  // input bit lands in the sticky region
  always_comb begin
    w_shl = '0;
    w_shr = '0;
    if (w_den) begin
      if (w_exp_ext >= c_nexp_one) begin
        w_shl = c_lzc_w'(w_den_lsh);
      end else if (w_den_rsh > c_in_width) begin
        w_shr = c_lzc_w'(IN_WIDTH);
      end else begin
        w_shr = c_lzc_w'(w_den_rsh);
      end
    end else if (w_lzc == '0) begin
      w_shr = c_lzc_w'(1);
    end else begin
      w_shl = w_lzc - c_lzc_w'(1);
    end
  end

  logic [IN_WIDTH-1:0]   r_s1_mant;
  logic [EXP_BITS-1:0]   r_s1_exp;
  logic [c_lzc_w-1:0]    r_s1_shl;
  logic [c_lzc_w-1:0]    r_s1_shr;
  logic                  r_s1_zero;
  logic                  r_s1_of;
  logic                  r_s1_sign;
  fpnew_pkg::roundmode_e r_s1_rm;
  logic                  r_s1_es;

  // Stage-1 valid and stage-2 valid; flush empties both
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_accept) r_s1_valid <= in_valid_i;
      if (w_s2_accept) r_s2_valid <= r_s1_valid;
    end
  end

  // Stage-1 data register, loaded on an input transfer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_mant <= '0;
      r_s1_exp  <= '0;
      r_s1_shl  <= '0;
      r_s1_shr  <= '0;
      r_s1_zero <= 1'b0;
      r_s1_of   <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_rm   <= fpnew_pkg::RNE;
      r_s1_es   <= 1'b0;
    end else if (w_s1_accept && in_valid_i) begin
      r_s1_mant <= mant_i;
      r_s1_exp  <= w_exp_field;
      r_s1_shl  <= w_shl;
      r_s1_shr  <= w_shr;
      r_s1_zero <= w_zero;
      r_s1_of   <= w_of;
      r_s1_sign <= sign_i;
      r_s1_rm   <= rnd_mode_i;
      r_s1_es   <= eff_sub_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: apply the shift, extract mantissa / round / sticky, pack
  // --------------------------------------------------------------------------
  logic [IN_WIDTH-1:0]          w_shifted;
  logic [IN_WIDTH-1:0]          w_lost;
  logic [MAN_BITS-1:0]          w_man;
  logic                         w_round;
  logic                         w_sticky;
  logic                         w_unused_lead;
  logic [EXP_BITS+MAN_BITS-1:0] w_abs;
  logic [1:0]                   w_rs;

  // Only one of the two shift amounts is ever non-zero
  assign {w_shifted, w_lost} = {r_s1_mant << r_s1_shl, {IN_WIDTH{1'b0}}} >> r_s1_shr;

  assign w_man         = w_shifted[IN_WIDTH-3 -: MAN_BITS];
  assign w_round       = w_shifted[IN_WIDTH-3-MAN_BITS];
  assign w_sticky      = (|w_shifted[IN_WIDTH-4-MAN_BITS:0]) | (|w_lost);
  // The integer bits are the implicit one (or zero); nothing is taken from them
  assign w_unused_lead = &{1'b0, w_shifted[IN_WIDTH-1:IN_WIDTH-2]};

  // Result select: zero, overflow (largest finite with RS=11) or normal/denormal
  always_comb begin
    w_abs = {r_s1_exp, w_man};
    w_rs  = {w_round, w_sticky};
    if (r_s1_zero) begin
      w_abs = '0;
      w_rs  = 2'b00;
    end else if (r_s1_of) begin
      w_abs = {c_exp_maxf, {MAN_BITS{1'b1}}};
      w_rs  = 2'b11;
    end
  end

  logic [EXP_BITS+MAN_BITS-1:0] r_abs;
  logic [1:0]                   r_rs;
  logic                         r_of;
  logic                         r_sign;
  fpnew_pkg::roundmode_e        r_rm;
  logic                         r_es;

  // Output register, held while the downstream stalls
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_abs  <= '0;
      r_rs   <= 2'b00;
      r_of   <= 1'b0;
      r_sign <= 1'b0;
      r_rm   <= fpnew_pkg::RNE;
      r_es   <= 1'b0;
    end else if (w_s2_accept && r_s1_valid) begin
      r_abs  <= w_abs;
      r_rs   <= w_rs;
      r_of   <= r_s1_of & ~r_s1_zero;
      r_sign <= r_s1_sign;
      r_rm   <= r_s1_rm;
      r_es   <= r_s1_es;
    end
  end

  assign abs_value_o     = r_abs;
  assign round_sticky_o  = r_rs;
  assign of_before_rnd_o = r_of;
  assign sign_o          = r_sign;
  assign rnd_mode_o      = r_rm;
  assign eff_sub_o       = r_es;

endmodule
`default_nettype wire

// File: tb/tb_fpnew_round_prep.sv
`default_nettype none
// ============================================================================
//  Module       : tb_fpnew_round_prep
//  Description  : Self-checking bench for fpnew_round_prep with a value-level
//                 reference model and a per-cycle scoreboard.
//  Revision     : 1.0 - initial release
// ============================================================================
module tb_fpnew_round_prep;

  localparam int EB = 8;
  localparam int MB = 23;
  localparam int IW = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_ni, flush_i, in_valid_i, in_ready_o, sign_i, eff_sub_i;
  logic signed [EB+1:0]  exp_i;
  logic [IW-1:0]         mant_i;
  fpnew_pkg::roundmode_e rnd_mode_i, rnd_mode_o;
  logic                  out_valid_o, out_ready_i, sign_o, eff_sub_o, of_before_rnd_o;
  logic [EB+MB-1:0]      abs_value_o;
  logic [1:0]            round_sticky_o;

  fpnew_round_prep #(.EXP_BITS(EB), .MAN_BITS(MB), .IN_WIDTH(IW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
    .rnd_mode_i(rnd_mode_i), .eff_sub_i(eff_sub_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .abs_value_o(abs_value_o), .sign_o(sign_o), .round_sticky_o(round_sticky_o),
    .rnd_mode_o(rnd_mode_o), .eff_sub_o(eff_sub_o), .of_before_rnd_o(of_before_rnd_o)
  );

  typedef struct {
    logic [EB+MB-1:0] abs;
    logic [1:0]       rs;
    logic             of;
    logic             sgn;
    logic [2:0]       rm;
    logic             es;
    int               tag;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   ncyc     = 0;
  bit   sb_on    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value = mant/2^(IW-2) * 2^(e-BIAS). Each set input bit is
  // placed at its weight relative to the result's lowest mantissa bit.
  function automatic exp_t model(input logic s, input int e, input logic [IW-1:0] m,
                                 input logic [2:0] rm, input logic es);
    exp_t r;
    int p, nexp, qq;
    logic [MB-1:0] man;
    logic rb, sb;
    r.sgn = s; r.rm = rm; r.es = es; r.of = 1'b0; r.abs = '0; r.rs = 2'b00; r.tag = 0;
    if (m == '0) return r;
    p = -1;
    for (int i = 0; i < IW; i++) if (m[i]) p = i;
    nexp = e + p - (IW - 2);
    if (nexp >= (1 << EB) - 1) begin
      r.abs = {EB'((1 << EB) - 2), {MB{1'b1}}};
      r.rs  = 2'b11;
      r.of  = 1'b1;
      return r;
    end
    man = '0; rb = 1'b0; sb = 1'b0;
    for (int i = 0; i < IW; i++) begin
      if (m[i]) begin
        // normal: leading one sits at position MB (implicit bit)
        // denormal: bit weight 2^(1-BIAS-MB) is position 0
        if (nexp >= 1) qq = i - p + MB;
        else           qq = i + e - (IW - 2) - 1 + MB;
        if (qq >= 0 && qq < MB) man[qq] = 1'b1;
        else if (qq == -1)      rb = 1'b1;
        else if (qq < -1)       sb = 1'b1;
      end
    end
    r.abs = {(nexp >= 1) ? EB'(nexp) : EB'(0), man};
    r.rs  = {rb, sb};
    return r;
  endfunction

  // Scoreboard: every cycle check handshake outputs and the head of the queue
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    ncyc++;
    if (sb_on) begin
      ev = (sbq.size() > 0) && (ncyc - sbq[0].tag >= 2);
      chk("out_valid", out_valid_o, ev);
      chk("in_ready", in_ready_o, (sbq.size() < 2) || out_ready_i);
      if (ev && out_valid_o) begin
        chk("abs_value", abs_value_o, sbq[0].abs);
        chk("round_sticky", round_sticky_o, sbq[0].rs);
        chk("of_before_rnd", of_before_rnd_o, sbq[0].of);
        chk("sign", sign_o, sbq[0].sgn);
        chk("rnd_mode", rnd_mode_o, sbq[0].rm);
        chk("eff_sub", eff_sub_o, sbq[0].es);
        if (out_ready_i) void'(sbq.pop_front());
      end
      if (!rst_ni || flush_i) begin
        sbq.delete();
      end else if (in_valid_i && in_ready_o) begin
        e = model(sign_i, int'(exp_i), mant_i, rnd_mode_i, eff_sub_i);
        e.tag = ncyc;
        sbq.push_back(e);
      end
    end
  end

  task automatic drive(input logic s, input int e, input logic [IW-1:0] m,
                       input logic [2:0] rm, input logic es);
    sign_i = s; exp_i = (EB+2)'(e); mant_i = m;
    rnd_mode_i = fpnew_pkg::roundmode_e'(rm); eff_sub_i = es;
  endtask

  task automatic send(input logic s, input int e, input logic [IW-1:0] m,
                      input logic [2:0] rm, input logic es, input bit rnd);
    int guard;
    guard = 0;
    drive(s, e, m, rm, es);
    in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o) begin
      guard++;
      if (guard > 100) begin
        checks++; failures++;
        $display("FAIL send_timeout: actual=in_ready stuck 0 required=accept within 100 cycles");
        break;
      end
      @(posedge clk); #1;
      if (rnd) out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    if (rnd) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready_i = 1'b1;
    while (sbq.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", sbq.size());
    end
  endtask

  logic [IW-1:0] bpm [3];
  int            bpe [3];

  initial begin
    exp_t r;
    int   acc;
    bit   hs;
    logic [63:0] rv;
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b0, 0, '0, 3'd0, 1'b0);

    // Hand-computed expectations that pin the model
    r = model(0, 127, 50'd1 << 48, 0, 0);
    chk("model_one_abs", r.abs, 31'h3F800000); chk("model_one_rs", r.rs, 2'b00);
    r = model(0, 127, 50'd1 << 49, 0, 0);
    chk("model_two_abs", r.abs, 31'h40000000);
    r = model(0, 127, (50'd1 << 48) | (50'd1 << 24), 0, 0);
    chk("model_round_abs", r.abs, 31'h3F800000); chk("model_round_rs", r.rs, 2'b10);
    r = model(0, 254, 50'd1 << 49, 0, 0);
    chk("model_ovf_abs", r.abs, 31'h7F7FFFFF); chk("model_ovf_rs", r.rs, 2'b11);
    chk("model_ovf_of", r.of, 1'b1);
    r = model(0, 0, 50'd1 << 48, 0, 0);
    chk("model_den_abs", r.abs, 31'h00400000); chk("model_den_rs", r.rs, 2'b00);
    r = model(0, -100, 50'd1, 0, 0);
    chk("model_tiny_abs", r.abs, 31'h0); chk("model_tiny_rs", r.rs, 2'b01);
    r = model(1, 50, 50'd0, 0, 0);
    chk("model_zero_abs", r.abs, 31'h0); chk("model_zero_rs", r.rs, 2'b00);

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_abs", abs_value_o, '0);
    chk("rst_rs", round_sticky_o, 2'b00);
    chk("rst_of", of_before_rnd_o, 1'b0);
    chk("rst_sign", sign_o, 1'b0);
    sb_on = 1'b1;
    @(posedge clk); #1;

    // Directed vectors (one op, then space so latency is seen in isolation)
    send(0, 127, 50'd1 << 48, 3'd0, 0, 0);
    repeat (3) @(posedge clk); #1;
    send(1, 127, 50'd1 << 49, 3'd1, 1, 0);
    send(0, 127, (50'd1 << 48) | (50'd1 << 24), 3'd2, 0, 0);
    send(0, 254, 50'd1 << 49, 3'd3, 1, 0);
    send(1, 0, 50'd1 << 48, 3'd4, 0, 0);
    send(0, -100, 50'd1, 3'd0, 1, 0);
    send(1, 77, 50'd0, 3'd1, 0, 0);
    send(0, 200, 50'h0_0000_0ABC_DEF1, 3'd2, 0, 0);
    send(0, 30, 50'h0_0000_0000_0F0F, 3'd0, 0, 0);
    send(0, 255, 50'd1 << 40, 3'd0, 0, 0);
    drain();

    // Backpressure: three ops offered with the output stalled
    bpm[0] = 50'd3 << 47; bpe[0] = 10;
    bpm[1] = 50'd5 << 30; bpe[1] = 140;
    bpm[2] = 50'd1 << 12; bpe[2] = 60;
    out_ready_i = 1'b0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      if (acc < 3) drive(0, bpe[acc], bpm[acc], 3'd0, 0);
      in_valid_i = (acc < 3);
      @(negedge clk);
      hs = in_valid_i && in_ready_o;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    @(negedge clk);
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready_o, 1'b0);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      drive(0, bpe[acc], bpm[acc], 3'd0, 0);
      in_valid_i = 1'b1;
      @(negedge clk);
      hs = in_ready_o;
      @(posedge clk); #1;
      if (hs) acc++;
    end
    in_valid_i = 1'b0;
    chk("bp_all_accepted", acc, 3);
    drain();

    // Flush with two ops in flight; the op offered in the flush cycle is dropped
    out_ready_i = 1'b0;
    send(0, 127, 50'd1 << 48, 3'd0, 0, 0);
    send(1, 128, 50'd1 << 49, 3'd1, 1, 0);
    drive(0, 90, 50'd7 << 20, 3'd2, 0);
    in_valid_i = 1'b1; flush_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid_o, 1'b0);
    repeat (5) @(posedge clk); #1;

    // Reset with two ops in flight
    out_ready_i = 1'b0;
    send(0, 100, 50'd9 << 40, 3'd0, 0, 0);
    send(1, 101, 50'd1 << 45, 3'd3, 1, 0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", out_valid_o, 1'b0);
    chk("rst2_abs", abs_value_o, '0);
    chk("rst2_rs", round_sticky_o, 2'b00);
    chk("rst2_of", of_before_rnd_o, 1'b0);
    repeat (5) @(posedge clk); #1;

    // Mixed operands with random stalls
    for (int k = 0; k < 30; k++) begin
      rv = {$urandom, $urandom};
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 340)) - 40,
           IW'(rv) >> $urandom_range(0, IW - 1), 3'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)), 1);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
